dly_tap_ctrl: RTL and testbench

- Tap controller directly upstream of the fine/coarse delay cells.
- Digitally filters early/late phase-detector samples and steps a mixed-radix tap code (coarse count plus fine count).
- Drives the cells' select inputs as thermometer vectors: o_sel_fine feeds the fine-cell select pins, o_sel_coarse feeds the coarse chain.
- Reports lock and saturation to the DLL top.

---
 rtl/dly_pkg.sv | 25 ++
 rtl/dly_tap_filt.sv | 54 +++++
 rtl/dly_tap_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_dly_tap_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dly_pkg.sv
// dly_pkg: shared definitions for the delay-line tap control blocks.
//   tap_state_t     : tap controller FSM states
//   VOTE_*          : encoding of one filtered phase-detector vote
//   therm_bit()     : one bit of a thermometer code, shared with other
//                     delay-line blocks that drive cell select vectors
package dly_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } tap_state_t;

    localparam logic [1:0] VOTE_HOLD = 2'b00;
    localparam logic [1:0] VOTE_UP   = 2'b01;
    localparam logic [1:0] VOTE_DN   = 2'b10;

    // Bit idx of the thermometer code for "level" cells selected:
    // cells 0..level-1 are engaged, i.e. value (1 << level) - 1.
    function automatic logic therm_bit(input int idx, input int level);
        return (idx < level);
    endfunction

endpackage

// File: rtl/dly_tap_filt.sv
// dly_tap_filt: early/late vote accumulator with threshold compare.
//   i_clk, i_rstn     : clock, asynchronous active-low reset
//   i_clr             : synchronous clear of the accumulator
//   i_vote            : VOTE_UP / VOTE_DN / VOTE_HOLD for this cycle
//   o_step_up/o_step_dn : combinational pulses, high in the cycle whose
//                       vote brings the accumulator to +/-FILT_TH, so the
//                       code register can step on that same edge
module dly_tap_filt
    import dly_pkg::*;
#(
    parameter int FILT_TH = 8
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_clr,
    input  logic [1:0] i_vote,
    output logic       o_step_up,
    output logic       o_step_dn
);

    // One spare bit beyond +FILT_TH so that -FILT_TH is representable.
    localparam int ACC_W = $clog2(FILT_TH + 1) + 1;

    localparam logic signed [ACC_W-1:0] ONE    = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] TH_POS = ACC_W'(FILT_TH);
    localparam logic signed [ACC_W-1:0] TH_NEG = -TH_POS;

    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] acc_sum;

    always_comb begin
        acc_sum = acc_reg;
        case (i_vote)
            VOTE_UP: acc_sum = acc_reg + ONE;
            VOTE_DN: acc_sum = acc_reg - ONE;
            default: acc_sum = acc_reg;
        endcase
    end

    // The accumulator never rests at +/-FILT_TH, so equality is sufficient.
    assign o_step_up = (acc_sum == TH_POS);
    assign o_step_dn = (acc_sum == TH_NEG);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            acc_reg <= '0;
        end else if (i_clr || o_step_up || o_step_dn) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_sum;
        end
    end

endmodule

// File: rtl/dly_tap_ctrl.sv
// dly_tap_ctrl: DLL tap controller. Filters early/late PD samples and
// steps a mixed-radix (coarse, fine) tap code driving the delay cells.
//   i_clk, i_rstn        : clock, asynchronous active-low reset
//   i_en                 : tracking enable (0 -> IDLE, code held)
//   i_pd_vld/up/dn       : phase-detector sample
//   o_sel_fine/coarse    : thermometer select vectors for the cells
//   o_code               : linear code coarse*(N_FINE+1)+fine
//   o_locked             : lock flag
//   o_sat_hi / o_sat_lo  : code at maximum / minimum
// Optional: define DLY_TAP_CTRL_OVR_EN to add i_ovr_vld / i_ovr_code,
// a direct code load (clamped to maximum) that wins over PD steps.
module dly_tap_ctrl
    import dly_pkg::*;
#(
    parameter int N_COARSE = 8,
    parameter int N_FINE   = 4,
    parameter int FILT_TH  = 8,
    parameter int SETTLE   = 4,
    parameter int LOCK_CNT = 16,
    localparam int CODE_W  = $clog2((N_COARSE + 1) * (N_FINE + 1))
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_en,
    input  logic                i_pd_vld,
    input  logic                i_pd_up,
    input  logic                i_pd_dn,
`ifdef DLY_TAP_CTRL_OVR_EN
    input  logic                i_ovr_vld,
    input  logic [CODE_W-1:0]   i_ovr_code,
`endif
    output logic [N_FINE-1:0]   o_sel_fine,
    output logic [N_COARSE-1:0] o_sel_coarse,
    output logic [CODE_W-1:0]   o_code,
    output logic                o_locked,
    output logic                o_sat_hi,
    output logic                o_sat_lo
);

    localparam int CW  = $clog2(N_COARSE + 1);
    localparam int FW  = $clog2(N_FINE + 1);
    localparam int LCW = $clog2(LOCK_CNT + 1);
    localparam int SW  = $clog2(SETTLE + 1);

    localparam logic [CW-1:0]  COARSE_MAX = CW'(N_COARSE);
    localparam logic [FW-1:0]  FINE_MAX   = FW'(N_FINE);
    localparam logic [LCW-1:0] LOCK_MAX   = LCW'(LOCK_CNT);

    tap_state_t          state_reg;
    logic [CW-1:0]       coarse_reg, coarse_next;
    logic [FW-1:0]       fine_reg, fine_next;
    logic [LCW-1:0]      lock_cnt_reg;
    logic [SW-1:0]       settle_cnt_reg;
    logic                locked_reg;
    logic                last_vld_reg;   // a step has been seen since lock
    logic                last_up_reg;    // direction of that step
    logic [N_FINE-1:0]   sel_fine_reg, sel_fine_next;
    logic [N_COARSE-1:0] sel_coarse_reg, sel_coarse_next;
    logic [CODE_W-1:0]   code_reg, code_next;
    logic                sat_hi_reg, sat_lo_reg;

    logic       sample_vld;
    logic [1:0] vote;
    logic       filt_up, filt_dn;
    logic       at_max, at_min;
    logic       do_up, do_dn;
    logic       ovr_vld;
    logic [CW-1:0] ovr_coarse;
    logic [FW-1:0] ovr_fine;

`ifdef DLY_TAP_CTRL_OVR_EN
    localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(N_COARSE * (N_FINE + 1) + N_FINE);
    logic [CODE_W-1:0] ovr_clamped;
    assign ovr_vld     = i_ovr_vld;
    assign ovr_clamped = (i_ovr_code > CODE_MAX) ? CODE_MAX : i_ovr_code;
    assign ovr_coarse  = CW'(ovr_clamped / CODE_W'(N_FINE + 1));
    assign ovr_fine    = FW'(ovr_clamped % CODE_W'(N_FINE + 1));
`else
    assign ovr_vld    = 1'b0;
    assign ovr_coarse = '0;
    assign ovr_fine   = '0;
`endif

    // PD samples only count while tracking; SETTLE and IDLE discard them.
    assign sample_vld = i_en && i_pd_vld &&
                        (state_reg == ST_TRACK || state_reg == ST_LOCKED);

    always_comb begin
        vote = VOTE_HOLD;
        if (sample_vld) begin
            if (i_pd_up && !i_pd_dn) begin
                vote = VOTE_UP;
            end else if (i_pd_dn && !i_pd_up) begin
                vote = VOTE_DN;
            end
        end
    end

    dly_tap_filt #(
        .FILT_TH (FILT_TH)
    ) u_filt (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_clr     (ovr_vld || !i_en),
        .i_vote    (vote),
        .o_step_up (filt_up),
        .o_step_dn (filt_dn)
    );

    assign at_max = (coarse_reg == COARSE_MAX) && (fine_reg == FINE_MAX);
    assign at_min = (coarse_reg == '0) && (fine_reg == '0);
    // A threshold hit at a saturated end is absorbed: not a step.
    assign do_up  = filt_up && !at_max && !ovr_vld;
    assign do_dn  = filt_dn && !at_min && !ovr_vld;

    always_comb begin
        coarse_next = coarse_reg;
        fine_next   = fine_reg;
        if (ovr_vld) begin
            coarse_next = ovr_coarse;
            fine_next   = ovr_fine;
        end else if (do_up) begin
            if (fine_reg != FINE_MAX) begin
                fine_next = fine_reg + FW'(1);
            end else begin
                fine_next   = '0;
                coarse_next = coarse_reg + CW'(1);
            end
        end else if (do_dn) begin
            if (fine_reg != '0) begin
                fine_next = fine_reg - FW'(1);
            end else begin
                fine_next   = FINE_MAX;
                coarse_next = coarse_reg - CW'(1);
            end
        end
        code_next = CODE_W'(int'(coarse_next) * (N_FINE + 1) + int'(fine_next));
    end

    // Select vectors are built from the next code so that every output
    // register updates on the same edge as the code itself.
    for (genvar gi = 0; gi < N_FINE; gi++) begin : g_sel_fine
        assign sel_fine_next[gi] = therm_bit(gi, int'(fine_next));
    end
    for (genvar gi = 0; gi < N_COARSE; gi++) begin : g_sel_coarse
        assign sel_coarse_next[gi] = therm_bit(gi, int'(coarse_next));
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg      <= ST_IDLE;
            coarse_reg     <= '0;
            fine_reg       <= '0;
            lock_cnt_reg   <= '0;
            settle_cnt_reg <= '0;
            locked_reg     <= 1'b0;
            last_vld_reg   <= 1'b0;
            last_up_reg    <= 1'b0;
            sel_fine_reg   <= '0;
            sel_coarse_reg <= '0;
            code_reg       <= '0;
            sat_hi_reg     <= 1'b0;
            sat_lo_reg     <= 1'b1;
        end else begin
            coarse_reg     <= coarse_next;
            fine_reg       <= fine_next;
            sel_fine_reg   <= sel_fine_next;
            sel_coarse_reg <= sel_coarse_next;
            code_reg       <= code_next;
            sat_hi_reg     <= (coarse_next == COARSE_MAX) && (fine_next == FINE_MAX);
            sat_lo_reg     <= (coarse_next == '0) && (fine_next == '0);

            if (ovr_vld) begin
                lock_cnt_reg   <= '0;
                settle_cnt_reg <= '0;
                locked_reg     <= 1'b0;
                last_vld_reg   <= 1'b0;
                state_reg      <= i_en ? ST_SETTLE : ST_IDLE;
            end else if (!i_en) begin
                lock_cnt_reg   <= '0;
                settle_cnt_reg <= '0;
                locked_reg     <= 1'b0;
                last_vld_reg   <= 1'b0;
                state_reg      <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg <= ST_TRACK;
                    end
                    ST_TRACK, ST_LOCKED: begin
                        if (do_up || do_dn) begin
                            lock_cnt_reg   <= '0;
                            settle_cnt_reg <= '0;
                            state_reg      <= ST_SETTLE;
                            // Dither (alternating steps) keeps lock; two
                            // steps in a row the same way mean real drift.
                            if (locked_reg && last_vld_reg && (last_up_reg == do_up)) begin
                                locked_reg   <= 1'b0;
                                last_vld_reg <= 1'b0;
                            end else begin
                                last_vld_reg <= 1'b1;
                                last_up_reg  <= do_up;
                            end
                        end else if (sample_vld) begin
                            if (lock_cnt_reg != LOCK_MAX) begin
                                lock_cnt_reg <= lock_cnt_reg + LCW'(1);
                            end
                            if (!locked_reg && (lock_cnt_reg >= LOCK_MAX - LCW'(1))) begin
                                locked_reg   <= 1'b1;
                                last_vld_reg <= 1'b0;
                                state_reg    <= ST_LOCKED;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_cnt_reg == SW'(SETTLE - 1)) begin
                            settle_cnt_reg <= '0;
                            state_reg      <= locked_reg ? ST_LOCKED : ST_TRACK;
                        end else begin
                            settle_cnt_reg <= settle_cnt_reg + SW'(1);
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_sel_fine   = sel_fine_reg;
    assign o_sel_coarse = sel_coarse_reg;
    assign o_code       = code_reg;
    assign o_locked     = locked_reg;
    assign o_sat_hi     = sat_hi_reg;
    assign o_sat_lo     = sat_lo_reg;

endmodule

// File: tb/tb_dly_tap_ctrl.sv
// tb_dly_tap_ctrl: directed-vector bench for dly_tap_ctrl (default
// parameters). Override vectors run when DLY_TAP_CTRL_OVR_EN is defined.
module tb_dly_tap_ctrl;

    localparam int N_COARSE = 8;
    localparam int N_FINE   = 4;
    localparam int CODE_W   = 6;

    logic                i_clk = 1'b0;
    logic                i_rstn = 1'b0;
    logic                i_en = 1'b0;
    logic                i_pd_vld = 1'b0;
    logic                i_pd_up = 1'b0;
    logic                i_pd_dn = 1'b0;
`ifdef DLY_TAP_CTRL_OVR_EN
    logic                i_ovr_vld = 1'b0;
    logic [CODE_W-1:0]   i_ovr_code = '0;
`endif
    logic [N_FINE-1:0]   o_sel_fine;
    logic [N_COARSE-1:0] o_sel_coarse;
    logic [CODE_W-1:0]   o_code;
    logic                o_locked;
    logic                o_sat_hi;
    logic                o_sat_lo;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 i_clk = ~i_clk;

    dly_tap_ctrl u_dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_en         (i_en),
        .i_pd_vld     (i_pd_vld),
        .i_pd_up      (i_pd_up),
        .i_pd_dn      (i_pd_dn),
`ifdef DLY_TAP_CTRL_OVR_EN
        .i_ovr_vld    (i_ovr_vld),
        .i_ovr_code   (i_ovr_code),
`endif
        .o_sel_fine   (o_sel_fine),
        .o_sel_coarse (o_sel_coarse),
        .o_code       (o_code),
        .o_locked     (o_locked),
        .o_sat_hi     (o_sat_hi),
        .o_sat_lo     (o_sat_lo)
    );

    task automatic check_val(input string tag, input int act, input int exp);
        chk_cnt++;
        if (act == exp) begin
            pass_cnt++;
            $display("check %-14s ok   value=%0d", tag, act);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // One clock with the given PD inputs; returns 1 time unit after the edge.
    task automatic pd_cycle(input logic vld, input logic up, input logic dn);
        i_pd_vld = vld;
        i_pd_up  = up;
        i_pd_dn  = dn;
        @(posedge i_clk);
        #1;
    endtask

    task automatic votes(input int n, input logic up, input logic dn);
        for (int k = 0; k < n; k++) pd_cycle(1'b1, up, dn);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) pd_cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Full step: threshold votes then wait out the settle window.
    task automatic step_up(input int n);
        for (int k = 0; k < n; k++) begin
            votes(8, 1'b1, 1'b0);
            idle(4);
        end
    endtask

    task automatic step_dn(input int n);
        for (int k = 0; k < n; k++) begin
            votes(8, 1'b0, 1'b1);
            idle(4);
        end
    endtask

    initial begin
        // Reset state
        idle(3);
        check_val("rst_code", int'(o_code), 0);
        check_val("rst_sel_fine", int'(o_sel_fine), 0);
        check_val("rst_sel_coarse", int'(o_sel_coarse), 0);
        check_val("rst_locked", int'(o_locked), 0);
        check_val("rst_sat_lo", int'(o_sat_lo), 1);
        check_val("rst_sat_hi", int'(o_sat_hi), 0);

        i_rstn = 1'b1;
        i_en   = 1'b1;
        idle(1);                       // IDLE -> TRACK

`ifdef DLY_TAP_CTRL_OVR_EN
        votes(7, 1'b1, 1'b0);
        i_ovr_vld  = 1'b1;
        i_ovr_code = 6'd23;
        pd_cycle(1'b1, 1'b1, 1'b0);    // threshold vote + override together
        check_val("ovr_code", int'(o_code), 23);
        check_val("ovr_sel_coarse", int'(o_sel_coarse), 8'h0F);
        check_val("ovr_sel_fine", int'(o_sel_fine), 4'h7);
        i_ovr_code = 6'd60;
        pd_cycle(1'b0, 1'b0, 1'b0);
        check_val("ovr_clamp", int'(o_code), 44);
        check_val("ovr_clamp_hi", int'(o_sat_hi), 1);
        i_ovr_code = 6'd0;
        pd_cycle(1'b0, 1'b0, 1'b0);
        i_ovr_vld = 1'b0;
        check_val("ovr_zero", int'(o_code), 0);
        idle(4);                       // SETTLE -> TRACK
`endif

        // First step on the 8th net up vote
        votes(7, 1'b1, 1'b0);
        check_val("pre_step", int'(o_code), 0);
        pd_cycle(1'b1, 1'b1, 1'b0);
        check_val("step1_code", int'(o_code), 1);
        check_val("step1_fine", int'(o_sel_fine), 4'b0001);
        check_val("step1_sat_lo", int'(o_sat_lo), 0);
        // Four votes inside SETTLE must be discarded
        votes(4, 1'b1, 1'b0);
        votes(7, 1'b1, 1'b0);
        check_val("settle_ignore", int'(o_code), 1);
        pd_cycle(1'b1, 1'b1, 1'b0);
        check_val("step2_code", int'(o_code), 2);
        idle(4);

        // Fine rollover into coarse
        step_up(3);
        check_val("roll_code", int'(o_code), 5);
        check_val("roll_coarse", int'(o_sel_coarse), 8'h01);
        check_val("roll_fine", int'(o_sel_fine), 0);

        // Climb to saturation
        step_up(39);
        check_val("max_code", int'(o_code), 44);
        check_val("max_sat_hi", int'(o_sat_hi), 1);
        check_val("max_coarse", int'(o_sel_coarse), 8'hFF);
        check_val("max_fine", int'(o_sel_fine), 4'hF);
        votes(8, 1'b1, 1'b0);
        check_val("sat_hold_hi", int'(o_code), 44);
        // Saturated step skips SETTLE: down votes count immediately
        votes(8, 1'b0, 1'b1);
        check_val("sat_no_settle", int'(o_code), 43);
        check_val("sat_hi_clear", int'(o_sat_hi), 0);
        check_val("no_lock_yet", int'(o_locked), 0);
        idle(4);

        // Step down mirror
        step_dn(3);
        check_val("dn_code40", int'(o_code), 40);
        check_val("dn40_fine", int'(o_sel_fine), 0);
        step_dn(1);
        check_val("dn_code39", int'(o_code), 39);
        check_val("dn39_coarse", int'(o_sel_coarse), 8'h7F);
        check_val("dn39_fine", int'(o_sel_fine), 4'hF);
        step_dn(39);
        check_val("min_code", int'(o_code), 0);
        check_val("min_sat_lo", int'(o_sat_lo), 1);
        votes(8, 1'b0, 1'b1);
        check_val("sat_hold_lo", int'(o_code), 0);

        // Disable/enable clears lock count; alternating votes reach lock
        i_en = 1'b0;
        idle(1);
        i_en = 1'b1;
        idle(1);
        for (int i = 1; i <= 100; i++) begin
            pd_cycle(1'b1, i[0], !i[0]);
            if (i == 15) check_val("alt_lock15", int'(o_locked), 0);
            if (i == 16) check_val("alt_lock16", int'(o_locked), 1);
        end
        check_val("alt_code", int'(o_code), 0);
        check_val("alt_locked", int'(o_locked), 1);
        votes(8, 1'b1, 1'b0);
        check_val("lk_step1", int'(o_locked), 1);
        idle(4);
        votes(8, 1'b1, 1'b0);
        check_val("lk_step2_code", int'(o_code), 2);
        check_val("lk_step2", int'(o_locked), 0);

        // Disable mid-SETTLE holds the code
        i_en = 1'b0;
        idle(1);
        check_val("dis_hold", int'(o_code), 2);
        i_en = 1'b1;
        idle(1);

        // Simultaneous up+dn: zero vote, lock counter still advances
        for (int i = 1; i <= 20; i++) begin
            pd_cycle(1'b1, 1'b1, 1'b1);
            if (i == 15) check_val("both_lock15", int'(o_locked), 0);
            if (i == 16) check_val("both_lock16", int'(o_locked), 1);
        end
        check_val("both_code", int'(o_code), 2);
        votes(7, 1'b1, 1'b0);
        check_val("both_acc0", int'(o_code), 2);
        pd_cycle(1'b1, 1'b1, 1'b0);
        check_val("both_step", int'(o_code), 3);
        idle(4);

        // Votes with i_pd_vld low are ignored
        for (int k = 0; k < 10; k++) pd_cycle(1'b0, 1'b1, 1'b0);
        check_val("novld_code", int'(o_code), 3);

        // Opposite-direction step keeps lock
        step_dn(1);
        check_val("dither_code", int'(o_code), 2);
        check_val("dither_lock", int'(o_locked), 1);

        // Reset asserted mid-SETTLE at code 13
        step_up(10);
        votes(8, 1'b1, 1'b0);
        check_val("pre_rst_code", int'(o_code), 13);
        #2;
        i_rstn = 1'b0;
        #1;
        check_val("arst_code", int'(o_code), 0);
        check_val("arst_fine", int'(o_sel_fine), 0);
        check_val("arst_coarse", int'(o_sel_coarse), 0);
        check_val("arst_locked", int'(o_locked), 0);
        check_val("arst_sat_lo", int'(o_sat_lo), 1);
        idle(2);
        i_rstn = 1'b1;
        idle(2);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
